// File: rtl/gpu_pkg.sv
// Shared GPU-side definitions: launcher FSM state encoding and default counter width.
package gpu_pkg;

  localparam int unsigned DEFAULT_CYCLE_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRST   = 3'd1,
    ST_CONFIG = 3'd2,
    ST_RUN    = 3'd3,
    ST_REPORT = 3'd4
  } launch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/kernel_launcher.sv
// Host-side kernel launcher: GPU reset pulse, DCR thread-count write, run until done, report status.
// Optional RUN abort after TIMEOUT_CYCLES when KERNEL_LAUNCHER_TIMEOUT_EN is defined.
module kernel_launcher
  import gpu_pkg::*;
#(
  parameter int unsigned CYCLE_BITS     = DEFAULT_CYCLE_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_launch_valid,
  output logic                  host_launch_ready,
  input  logic [7:0]            host_thread_count,
  output logic                  host_status_valid,
  input  logic                  host_status_ready,
  output logic [CYCLE_BITS-1:0] host_status_cycles,
  output logic                  host_status_error,
  output logic                  gpu_reset,
  output logic                  device_control_write_enable,
  output logic [7:0]            device_control_data,
  output logic                  start,
  input  logic                  done
);

  launch_state_t state;
  logic [7:0]    thread_count;
  logic          accept;
  logic          cnt_clear;
  logic          cnt_enable;
  logic          timeout_hit;

  assign accept     = (state == ST_IDLE) && host_launch_valid && host_launch_ready;
  assign cnt_clear  = !reset || accept;
  assign cnt_enable = (state == ST_RUN);

  // The counter register itself is the status field; it freezes once RUN is left.
  sat_counter #(.WIDTH(CYCLE_BITS)) u_cycle_counter (
    .clk    (clk),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (host_status_cycles)
  );

`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
  assign timeout_hit = (host_status_cycles == CYCLE_BITS'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                       <= ST_IDLE;
      thread_count                <= '0;
      host_launch_ready           <= 1'b0;
      host_status_valid           <= 1'b0;
      host_status_error           <= 1'b0;
      device_control_write_enable <= 1'b0;
      device_control_data         <= '0;
      start                       <= 1'b0;
      gpu_reset                   <= 1'b1;
    end else begin
      gpu_reset                   <= 1'b0;
      device_control_write_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          host_launch_ready <= 1'b1;
          if (accept) begin
            host_launch_ready <= 1'b0;
            thread_count      <= host_thread_count;
            if (host_thread_count == '0) begin
              state             <= ST_REPORT;
              host_status_valid <= 1'b1;
              host_status_error <= 1'b1;
            end else begin
              state     <= ST_GRST;
              gpu_reset <= 1'b1;
            end
          end
        end
        ST_GRST: begin
          state                       <= ST_CONFIG;
          device_control_write_enable <= 1'b1;
          device_control_data         <= thread_count;
        end
        ST_CONFIG: begin
          state <= ST_RUN;
          start <= 1'b1;
        end
        ST_RUN: begin
          // done wins over a timeout landing on the same edge
          if (done || timeout_hit) begin
            state             <= ST_REPORT;
            start             <= 1'b0;
            host_status_valid <= 1'b1;
            host_status_error <= !done;
          end
        end
        ST_REPORT: begin
          if (host_status_ready) begin
            state             <= ST_IDLE;
            host_status_valid <= 1'b0;
            host_launch_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
